// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: enable in, word/valid/error pulses out.
interface uart_rx_if #(
    parameter int unsigned PAYLOAD_BITS = 8
);
    logic                    uart_rx_en;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_break;

    modport master (
        input  uart_rx_en,
        output uart_rx_valid,
        output uart_rx_data,
        output uart_rx_frame_err,
        output uart_rx_break
    );

    modport slave (
        output uart_rx_en,
        input  uart_rx_valid,
        input  uart_rx_data,
        input  uart_rx_frame_err,
        input  uart_rx_break
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first payload, stop-bit check with valid/frame-error/break pulses.
// Optional macro UART_RX_MAJORITY_EN: each sample is the 2-of-3 majority of the last three rxd_s values.
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      uart_rxd,
    uart_rx_if.master rx
);
    localparam int unsigned BIT_P          = 1_000_000_000 / BIT_RATE;
    localparam int unsigned CLK_P          = 1_000_000_000 / CLK_HZ;
    localparam int unsigned CYCLES_PER_BIT = BIT_P / CLK_P;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CW             = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned BW             = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] HALF_TGT  = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_TGT   = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CYCLES_PER_BIT must be at least 4");
        end
        if (PAYLOAD_BITS < 1 || PAYLOAD_BITS > 15) begin : g_bad_payload
            $error("uart_rx: PAYLOAD_BITS must be 1..15");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx: STOP_BITS must be 1..2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RECV,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] sreg_q, sreg_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    stop_ok_q, stop_ok_d;
    logic                    armed_q, armed_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;

    logic [1:0] sync_q;
    logic       rxd_s;
    logic       sample;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    logic [2:0] win;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign win    = {hist_q, rxd_s};
    assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
`else
    assign sample = rxd_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        data_d    = data_q;
        stop_ok_d = stop_ok_q;
        armed_d   = armed_q | rxd_s;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        brk_d     = 1'b0;

        if (state_q != S_IDLE && !rx.uart_rx_en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d     = '0;
                    bit_d     = '0;
                    stop_ok_d = 1'b1;
                    // After a framing error the line must go high before a new start is accepted
                    if (rx.uart_rx_en && !rxd_s && armed_q) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_TGT) begin
                        state_d = sample ? S_IDLE : S_RECV;
                    end
                end
                S_RECV: begin
                    if (cnt_q == BIT_TGT) begin
                        cnt_d                 = '0;
                        sreg_d                = sreg_q >> 1;
                        sreg_d[PAYLOAD_BITS-1] = sample;
                        bit_d                 = bit_q + 1'b1;
                        if (bit_q == LAST_DATA) begin
                            state_d = S_STOP;
                            bit_d   = '0;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_TGT) begin
                        cnt_d     = '0;
                        stop_ok_d = stop_ok_q & sample;
                        bit_d     = bit_q + 1'b1;
                        if (bit_q == LAST_STOP) begin
                            state_d = S_IDLE;
                            if (stop_ok_q & sample) begin
                                data_d  = sreg_q;
                                valid_d = 1'b1;
                            end else begin
                                ferr_d  = 1'b1;
                                brk_d   = (sreg_q == '0);
                                armed_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sreg_q    <= '0;
            data_q    <= '0;
            stop_ok_q <= 1'b1;
            armed_q   <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            data_q    <= data_d;
            stop_ok_q <= stop_ok_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    assign rx.uart_rx_valid     = valid_q;
    assign rx.uart_rx_data      = data_q;
    assign rx.uart_rx_frame_err = ferr_q;
    assign rx.uart_rx_break     = brk_q;

    a_valid_ferr_excl : assert property (@(posedge clk) disable iff (!resetn) !(valid_q && ferr_q));
    a_break_with_ferr : assert property (@(posedge clk) disable iff (!resetn) brk_q |-> ferr_q);
    a_valid_one_cycle : assert property (@(posedge clk) disable iff (!resetn) valid_q |=> !valid_q);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame bench for uart_rx; expected pulses are decoded from the driven waveform by bit-time arithmetic.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned BIT_RATE = 100_000;
    localparam int P = 8;
    localparam int S = 1;
    localparam int C = 10;
    localparam int H = 5;
    localparam int N = 12000;

    logic clk = 1'b0;
    logic resetn;
    logic uart_rxd;

    uart_rx_if #(.PAYLOAD_BITS(P)) rx_if ();

    uart_rx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(P),
        .STOP_BITS   (S)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .uart_rxd(uart_rxd),
        .rx      (rx_if)
    );

    always #5 clk = ~clk;

    bit       pin_a [N];
    bit       en_a  [N];
    bit       rst_a [N];
    bit       rs    [N];
    bit       ev_v  [N];
    bit       ev_f  [N];
    bit       ev_b  [N];
    bit [7:0] ev_w  [N];
    bit [7:0] exp_d [N];
    int wp;

    int total, bad;
    int s_a5, s_00, s_3c, s_lo, s_g, s_rst, s_81, s_spk;
    int cnt_lo_f, cnt_lo_b, cnt_g;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    task automatic put(input bit p, input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < N) begin
                pin_a[wp] = p;
                en_a[wp]  = 1'b1;
                rst_a[wp] = 1'b1;
                wp++;
            end
        end
    endtask

    task automatic send(input logic [7:0] w, input bit stop_v);
        put(1'b0, C);
        for (int k = 0; k < P; k++) put(w[k], C);
        put(stop_v, C * S);
    endtask

    task automatic build();
        wp = 0;
        put(1'b1, 6);
        for (int i = 0; i < 6; i++) rst_a[i] = 1'b0;
        put(1'b1, 20);
        s_a5 = wp;  send(8'hA5, 1'b1); put(1'b1, 20);
        s_00 = wp;  send(8'h00, 1'b1); send(8'hFF, 1'b1); put(1'b1, 20);
        s_3c = wp;  send(8'h3C, 1'b0); put(1'b1, 20);
        s_lo = wp;  put(1'b0, 20 * C); put(1'b1, 30);
        s_g  = wp;  put(1'b0, 3); put(1'b1, 30);
        // frame 0x55 cut short by reset partway through bit 4
        put(1'b0, C);
        put(1'b1, C); put(1'b0, C); put(1'b1, C); put(1'b0, C);
        put(1'b1, 2);
        s_rst = wp; put(1'b1, 5);
        for (int i = 0; i < 5; i++) rst_a[s_rst + i] = 1'b0;
        put(1'b1, 20);
        s_81 = wp;  send(8'h81, 1'b1); put(1'b1, 20);
        begin
            int s;
            s = wp; send(8'h5A, 1'b1);
            for (int i = 40; i < 43; i++) en_a[s + i] = 1'b0;
            put(1'b1, 120);
        end
`ifdef UART_RX_MAJORITY_EN
        s_spk = wp; send(8'h00, 1'b1);
        pin_a[s_spk + H + C * 4] = 1'b1;
        put(1'b1, 20);
`endif
        for (int i = 0; i < 40; i++) begin
            int       k;
            int       s;
            logic [7:0] w;
            if (wp > N - 400) break;
            k = $urandom_range(0, 9);
            w = 8'($urandom);
            s = wp;
            case (k)
                0: put(1'b0, $urandom_range(1, 4));
                1: begin send(w, 1'b1); en_a[s + $urandom_range(10, 95)] = 1'b0; end
                2: send(w, 1'b0);
                3: begin send(w, 1'b1); for (int j = 0; j < 15; j++) en_a[s + j] = 1'b0; end
                default: send(w, 1'b1);
            endcase
            put(1'b1, $urandom_range(0, 12));
        end
        put(1'b1, 150);
    endtask

    function automatic bit smp(input int c);
`ifdef UART_RX_MAJORITY_EN
        int n;
        n = int'(rs[c]) + int'(rs[c-1]) + int'(rs[c-2]);
        return n >= 2;
`else
        return rs[c];
`endif
    endfunction

    task automatic model();
        bit f1 [N];
        int c;
        bit armed;
        bit [7:0] cur;
        for (int i = 0; i < wp; i++) begin
            bit ok;
            ok    = (i > 0) && rst_a[i-1] && rst_a[i];
            f1[i] = ok ? pin_a[i-1] : 1'b1;
            rs[i] = ok ? f1[i-1] : 1'b1;
        end
        c = 0;
        armed = 1'b1;
        while (c < wp) begin
            int t, last, abort_at;
            bit glitch, good;
            bit [7:0] w;
            if (!rst_a[c]) begin armed = 1'b1; c++; continue; end
            if (!(en_a[c] && !rs[c] && armed)) begin
                if (rs[c]) armed = 1'b1;
                c++;
                continue;
            end
            t = c;
            glitch = smp(t + H);
            last = glitch ? t + H : t + H + (P + S) * C;
            if (last + 1 >= wp) break;
            abort_at = -1;
            for (int r = t + 1; r <= last + 1; r++) begin
                if (!rst_a[r]) begin abort_at = r; break; end
                if (r <= last && !en_a[r]) begin abort_at = r + 1; break; end
            end
            if (abort_at >= 0) begin c = abort_at; continue; end
            if (glitch) begin c = last + 1; continue; end
            for (int k = 0; k < P; k++) w[k] = smp(t + H + (k + 1) * C);
            good = 1'b1;
            for (int s = 1; s <= S; s++) good &= smp(t + H + (P + s) * C);
            if (good) begin
                ev_v[last+1] = 1'b1;
                ev_w[last+1] = w;
            end else begin
                ev_f[last+1] = 1'b1;
                ev_b[last+1] = (w == 8'h00);
                armed = 1'b0;
            end
            c = last + 1;
        end
        cur = 8'h00;
        for (int i = 0; i < wp; i++) begin
            if (!rst_a[i]) cur = 8'h00;
            else if (ev_v[i]) cur = ev_w[i];
            exp_d[i] = cur;
        end
    endtask

    task automatic check(input int c);
        chk("valid",     c, rx_if.uart_rx_valid,     ev_v[c]);
        chk("frame_err", c, rx_if.uart_rx_frame_err, ev_f[c]);
        chk("break",     c, rx_if.uart_rx_break,     ev_b[c]);
        chk("data",      c, rx_if.uart_rx_data,      exp_d[c]);
        if (c == 2) chk("reset_data", c, rx_if.uart_rx_data, 8'h00);
        if (c == s_a5 + 97) chk("a5_not_early", c, rx_if.uart_rx_valid, 1'b0);
        if (c == s_a5 + 98) begin
            chk("a5_valid", c, rx_if.uart_rx_valid, 1'b1);
            chk("a5_data",  c, rx_if.uart_rx_data,  8'hA5);
        end
        if (c == s_00 + 98)  chk("b2b_first",  c, {rx_if.uart_rx_valid, rx_if.uart_rx_data}, {1'b1, 8'h00});
        if (c == s_00 + 198) chk("b2b_second", c, {rx_if.uart_rx_valid, rx_if.uart_rx_data}, {1'b1, 8'hFF});
        if (c == s_3c + 98) begin
            chk("3c_ferr", c, {rx_if.uart_rx_frame_err, rx_if.uart_rx_break}, 2'b10);
            chk("3c_data_held", c, rx_if.uart_rx_data, 8'hFF);
        end
        if (c == s_lo + 98) chk("lo_break", c, {rx_if.uart_rx_frame_err, rx_if.uart_rx_break}, 2'b11);
        if (c >= s_lo && c < s_lo + 230) begin
            cnt_lo_f += int'(rx_if.uart_rx_frame_err);
            cnt_lo_b += int'(rx_if.uart_rx_break);
        end
        if (c >= s_g && c < s_g + 33)
            cnt_g += int'(rx_if.uart_rx_valid) + int'(rx_if.uart_rx_frame_err);
        if (c == s_rst + 2) chk("rst_outputs", c,
            {rx_if.uart_rx_valid, rx_if.uart_rx_frame_err, rx_if.uart_rx_break, rx_if.uart_rx_data}, 11'h0);
        if (c == s_81 + 98) chk("post_reset_81", c, {rx_if.uart_rx_valid, rx_if.uart_rx_data}, {1'b1, 8'h81});
        if (c == s_spk + 98) chk("spike_data", c, {rx_if.uart_rx_valid, rx_if.uart_rx_data}, {1'b1, 8'h00});
    endtask

    initial begin
        total = 0; bad = 0;
        cnt_lo_f = 0; cnt_lo_b = 0; cnt_g = 0;
        s_spk = -1000;
        resetn = 1'b0;
        uart_rxd = 1'b1;
        rx_if.uart_rx_en = 1'b0;
        build();
        model();

        chk("model_a5_v",  -1, ev_v[s_a5 + 98], 1'b1);
        chk("model_a5_w",  -1, ev_w[s_a5 + 98], 8'hA5);
        chk("model_ff_w",  -1, ev_w[s_00 + 198], 8'hFF);
        chk("model_3c_f",  -1, {ev_f[s_3c + 98], ev_b[s_3c + 98]}, 2'b10);
        chk("model_lo_b",  -1, {ev_f[s_lo + 98], ev_b[s_lo + 98]}, 2'b11);
        chk("model_81_w",  -1, {ev_v[s_81 + 98], ev_w[s_81 + 98]}, {1'b1, 8'h81});

        for (int c = 0; c < wp; c++) begin
            @(posedge clk);
            #1;
            uart_rxd         = pin_a[c];
            rx_if.uart_rx_en = en_a[c];
            resetn           = rst_a[c];
            @(negedge clk);
            check(c);
        end

        chk("lo_ferr_once",  0, cnt_lo_f, 1);
        chk("lo_break_once", 0, cnt_lo_b, 1);
        chk("glitch_quiet",  0, cnt_g, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
